// File: rtl/rr_stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package rr_stream_mux_pkg;

  localparam int DEFAULT_NCH = 3;
  localparam int RST_PTR     = 0;

  // Ceiling log2, at least 1 so a 2-channel mux still gets a 1-bit index.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// Round-robin arbiter: rotating pointer plus priority encode from the pointer.
// Define RR_STREAM_MUX_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer).
module rr_arbiter
  import rr_stream_mux_pkg::*;
#(
  parameter int  NCH   = DEFAULT_NCH,
  localparam int SEL_W = clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req,
  input  logic             advance,
  output logic [NCH-1:0]   grant,
  output logic [SEL_W-1:0] gidx
);

  logic [SEL_W-1:0] ptr;

  always_comb begin
    int               j;
    logic             found;
    logic [SEL_W-1:0] idx;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    j     = 0;
    idx   = '0;
    // Walk the channels starting at the pointer, wrapping past NCH-1.
    for (int k = 0; k < NCH; k++) begin
      j = int'(ptr) + k;
      if (j >= NCH) j = j - NCH;
      idx = SEL_W'(j);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

`ifdef RR_STREAM_MUX_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = ^{clk, rst, advance};
  assign ptr       = SEL_W'(RST_PTR);
`else
  logic [SEL_W-1:0] ptr_reg;
  logic [SEL_W-1:0] ptr_next;

  assign ptr_next = (gidx == SEL_W'(NCH - 1)) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= SEL_W'(RST_PTR);
    end else if (advance) begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;
`endif

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with round-robin arbitration and one output register stage.
// Define RR_STREAM_MUX_FIXED_PRIO_EN to build the arbiter as fixed priority.
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter int  N     = 32,
  parameter int  NCH   = DEFAULT_NCH,
  localparam int SEL_W = clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH*N-1:0] in_data,
  input  logic [NCH-1:0]   in_valid,
  output logic [NCH-1:0]   in_ready,
  output logic [N-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [N-1:0]     ch_data [NCH];
  logic [NCH-1:0]   grant;
  logic [SEL_W-1:0] gidx;
  logic             load;
  logic             advance;

  logic [N-1:0]     out_data_reg;
  logic [SEL_W-1:0] out_sel_reg;
  logic             out_valid_reg;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*N +: N];
    end
  endgenerate

  assign load    = ~out_valid_reg | out_ready;
  assign advance = load & (|grant);

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (in_valid),
    .advance (advance),
    .grant   (grant),
    .gidx    (gidx)
  );

  // Sources must see no accept while reset is held, even mid-cycle.
  assign in_ready = rst ? '0 : (grant & {NCH{load}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
    end else if (load) begin
      if (|grant) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= ch_data[gidx];
        out_sel_reg   <= gidx;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench for rr_stream_mux: directed phases plus randomized traffic.
module tb_rr_stream_mux;

  localparam int N     = 32;
  localparam int NCH   = 3;
  localparam int SEL_W = 2;

  logic             clk;
  logic             rst;
  logic [NCH*N-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_ready;
  logic [N-1:0]     out_data;
  logic [SEL_W-1:0] out_sel;
  logic             out_valid;
  logic             out_ready;

  rr_stream_mux #(.N(N), .NCH(NCH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [31:0] data;
  } beat_t;

  beat_t       q[$];
  int          total = 0;
  int          bad   = 0;
  bit          sv[NCH];
  logic [31:0] sd[NCH];
  int          ptr_m = 0;
  bit          m_full = 0;
  int          staged = 0;
  int          last_win = -1;
  logic [31:0] last_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of source behaviour plus the reference model's view of the coming edge.
  task automatic step(input logic [2:0] new_mask, input bit rnd, input logic rdy);
    bit          load;
    int          win;
    int          c;
    logic [2:0]  exp_rdy;
    staged   = 0;
    last_win = -1;
    for (int i = 0; i < NCH; i++) begin
      if (!sv[i] && new_mask[i] && (!rnd || $urandom_range(0, 1) == 1)) begin
        sv[i] = 1'b1;
        sd[i] = rnd ? $urandom : 32'hA0 + 32'h11 * i;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      in_valid[i]          = sv[i];
      in_data[i*N +: N]    = sd[i];
    end
    out_ready = rdy;
    #1;
    load = !m_full || rdy;
    win  = -1;
    for (int k = 0; k < NCH; k++) begin
      c = (ptr_m + k) % NCH;
      if (win < 0 && sv[c]) win = c;
    end
    exp_rdy = '0;
    if (load && win >= 0) exp_rdy[win] = 1'b1;
    check("in_ready", {61'd0, in_ready}, {61'd0, exp_rdy});
    if (load) begin
      if (win >= 0) begin
        q.push_back('{win, sd[win]});
        staged   = 1;
        last_win = win;
        sv[win]  = 1'b0;
        m_full   = 1'b1;
`ifndef RR_STREAM_MUX_FIXED_PRIO_EN
        ptr_m    = (win + 1) % NCH;
`endif
      end else begin
        m_full = 1'b0;
      end
    end
  endtask

  task automatic cycle(input logic [2:0] new_mask, input bit rnd, input logic rdy);
    @(posedge clk);
    #1;
    step(new_mask, rnd, rdy);
  endtask

  // Assert reset between edges while a beat is held, then restart the model.
  task automatic reset_mid();
    #1;
    rst = 1'b1;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_sel", {62'd0, out_sel}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_in_ready", {61'd0, in_ready}, 64'd0);
    q.delete();
    m_full    = 1'b0;
    ptr_m     = 0;
    staged    = 0;
    last_data = '0;
    if (last_win >= 0) sv[last_win] = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(3'b111, 1'b0, 1'b1);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  initial begin
    int nvis;
    forever begin
      @(negedge clk);
      if (!rst) begin
        nvis = q.size() - staged;
        check("out_valid", {63'd0, out_valid}, {63'd0, (nvis > 0)});
        if (out_valid && nvis > 0) begin
          check("out_sel", {62'd0, out_sel}, 64'(q[0].sel));
          check("out_data", {32'd0, out_data}, {32'd0, q[0].data});
          $display("beat sel=%0d data=%08h ready=%0b", out_sel, out_data, out_ready);
          if (out_ready) begin
            last_data = q[0].data;
            void'(q.pop_front());
          end
        end else if (!out_valid) begin
          check("idle_hold", {32'd0, out_data}, {32'd0, last_data});
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 3'b111;
    in_data   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      sv[i] = 1'b0;
      sd[i] = '0;
    end
    #2;
    check("reset_in_ready", {61'd0, in_ready}, 64'd0);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_out_data", {32'd0, out_data}, 64'd0);
    check("reset_out_sel", {62'd0, out_sel}, 64'd0);
    in_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Fair cycling with all channels continuously requesting
    repeat (8) cycle(3'b111, 1'b0, 1'b1);
    // Backpressure for 4 cycles, then release
    repeat (4) cycle(3'b111, 1'b0, 1'b0);
    repeat (3) cycle(3'b111, 1'b0, 1'b1);
    // Drain to idle, then a lone request on channel 1
    repeat (5) cycle(3'b000, 1'b0, 1'b1);
    cycle(3'b010, 1'b0, 1'b1);
    repeat (3) cycle(3'b000, 1'b0, 1'b1);
    // Skip and wrap: lone channel 0 twice, then channels 0 and 2 together
    cycle(3'b001, 1'b0, 1'b1);
    cycle(3'b000, 1'b0, 1'b1);
    cycle(3'b001, 1'b0, 1'b1);
    cycle(3'b000, 1'b0, 1'b1);
    cycle(3'b101, 1'b0, 1'b1);
    repeat (3) cycle(3'b000, 1'b0, 1'b1);
    // Reset while a beat is stalled on the output
    cycle(3'b010, 1'b0, 1'b0);
    cycle(3'b101, 1'b0, 1'b0);
    reset_mid();
    repeat (4) cycle(3'b111, 1'b0, 1'b1);
    // Randomized traffic with random sink stalls
    repeat (2000) cycle(3'($urandom_range(0, 7)), 1'b1, ($urandom_range(0, 3) != 0));
    repeat (10) cycle(3'b000, 1'b0, 1'b1);
    @(negedge clk);
    check("drain_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
